// File: rtl/char_overlay_scan_if.sv
// Host-side write port of the character overlay buffer: valid/ready write
// handshake plus the single-cycle clear request.
interface char_overlay_scan_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_addr;
  logic [4:0] wr_char;
  logic       clr;

  modport master (output wr_valid, output wr_addr, output wr_char, output clr,
                  input  wr_ready);
  modport slave  (input  wr_valid, input  wr_addr, input  wr_char, input  clr,
                  output wr_ready);
endinterface

// File: rtl/char_overlay_scan.sv
// Text-overlay scanner: maps each video pixel onto a 32x32 glyph tile of a
// small character buffer, drives the glyph ROM and returns a pixel-aligned
// overlay bit with syncs delayed to match (fixed 4-cycle latency).
module char_overlay_scan #(
  parameter int ORIGIN_X = 64,
  parameter int ORIGIN_Y = 32,
  parameter int NUM_COLS = 16,
  parameter int NUM_ROWS = 2,
  parameter int BLANK    = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        pix_valid,
  input  logic        hsync_in,
  input  logic        vsync_in,
  char_overlay_scan_if.slave wr,
  output logic [4:0]  char_sel,
  output logic [5:0]  char_row,
  output logic [5:0]  char_col,
  input  logic        glyph_pix,
  output logic        ovl_pix,
  output logic        ovl_hit,
  output logic        valid_out,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int          DEPTH      = NUM_COLS * NUM_ROWS;
  localparam int          AW         = $clog2(DEPTH);
  localparam logic [10:0] X_LO       = 11'(ORIGIN_X);
  localparam logic [10:0] X_HI       = 11'(ORIGIN_X + 32 * NUM_COLS);
  localparam logic [10:0] Y_LO       = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI       = 11'(ORIGIN_Y + 32 * NUM_ROWS);
  localparam logic [4:0]  BLANK_CODE = 5'(BLANK);
  localparam logic [4:0]  LAST_IDX   = 5'(DEPTH - 1);
  localparam logic [4:0]  MAX_DRAWN  = 5'd16;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       mem_we;
  logic [4:0] mem_waddr;
  logic [4:0] mem_wdata;
  logic [4:0] mem_q [DEPTH];

  logic [9:0] dx, dy;
  logic       hit_0;
  logic [4:0] addr_0;

  logic       s1_hit_q, s1_hit_d;
  logic [4:0] s1_addr_q, s1_addr_d;
  logic [4:0] s1_row_q, s1_row_d;
  logic [4:0] s1_col_q, s1_col_d;
  logic [4:0] char_sel_q, char_sel_d;
  logic [4:0] char_row_q, char_row_d;
  logic [4:0] char_col_q, char_col_d;
  logic       s2_hit_q, s2_hit_d;
  logic       s3_hit_q, s3_hit_d;
  logic       s3_ok_q, s3_ok_d;
  logic       ovl_pix_q, ovl_pix_d;
  logic       ovl_hit_q, ovl_hit_d;
  logic [3:0][2:0] sync_q, sync_d;

  // Write FSM: host writes while idle, otherwise sweep BLANK over every entry.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr.wr_ready = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = wr.wr_addr;
    mem_wdata   = wr.wr_char;
    unique case (state_q)
      ST_IDLE: begin
        wr.wr_ready = 1'b1;
        mem_we      = wr.wr_valid && ({1'b0, wr.wr_addr} < 6'(DEPTH));
        if (wr.clr) begin
          state_d = ST_CLEAR;
          cnt_d   = 5'd0;
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = BLANK_CODE;
        if (wr.clr) begin
          cnt_d = 5'd0;
        end else if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
    endcase
  end

  // FSM registers; reset lands in CLEAR so the buffer blanks itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Character buffer storage; the read happens in the char_sel register below.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr[AW-1:0]] <= mem_wdata;
    end
  end

  // Next-state for the scan pipeline: window test, tile lookup and delays.
  always_comb begin
    dx     = pix_x - 10'(ORIGIN_X);
    dy     = pix_y - 10'(ORIGIN_Y);
    hit_0  = pix_valid
             && ({1'b0, pix_x} >= X_LO) && ({1'b0, pix_x} < X_HI)
             && ({1'b0, pix_y} >= Y_LO) && ({1'b0, pix_y} < Y_HI);
    addr_0 = 5'(int'(dy[9:5]) * NUM_COLS + int'(dx[9:5]));

    s1_hit_d   = hit_0;
    s1_addr_d  = addr_0;
    s1_row_d   = dy[4:0];
    s1_col_d   = dx[4:0];

    char_sel_d = s1_hit_q ? mem_q[s1_addr_q[AW-1:0]] : BLANK_CODE;
    char_row_d = s1_hit_q ? s1_row_q : 5'd0;
    char_col_d = s1_hit_q ? s1_col_q : 5'd0;
    s2_hit_d   = s1_hit_q;

    s3_hit_d   = s2_hit_q;
    s3_ok_d    = (char_sel_q <= MAX_DRAWN);

    ovl_pix_d  = s3_hit_q & s3_ok_q & glyph_pix;
    ovl_hit_d  = s3_hit_q;

    sync_d[0]  = {pix_valid, hsync_in, vsync_in};
    sync_d[1]  = sync_q[0];
    sync_d[2]  = sync_q[1];
    sync_d[3]  = sync_q[2];
  end

  // Scan pipeline registers; everything clears to idle, char_sel to BLANK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_hit_q   <= 1'b0;
      s1_addr_q  <= 5'd0;
      s1_row_q   <= 5'd0;
      s1_col_q   <= 5'd0;
      char_sel_q <= BLANK_CODE;
      char_row_q <= 5'd0;
      char_col_q <= 5'd0;
      s2_hit_q   <= 1'b0;
      s3_hit_q   <= 1'b0;
      s3_ok_q    <= 1'b0;
      ovl_pix_q  <= 1'b0;
      ovl_hit_q  <= 1'b0;
      sync_q     <= '0;
    end else begin
      s1_hit_q   <= s1_hit_d;
      s1_addr_q  <= s1_addr_d;
      s1_row_q   <= s1_row_d;
      s1_col_q   <= s1_col_d;
      char_sel_q <= char_sel_d;
      char_row_q <= char_row_d;
      char_col_q <= char_col_d;
      s2_hit_q   <= s2_hit_d;
      s3_hit_q   <= s3_hit_d;
      s3_ok_q    <= s3_ok_d;
      ovl_pix_q  <= ovl_pix_d;
      ovl_hit_q  <= ovl_hit_d;
      sync_q     <= sync_d;
    end
  end

  assign char_sel  = char_sel_q;
  assign char_row  = {1'b0, char_row_q};
  assign char_col  = {1'b0, char_col_q};
  assign ovl_pix   = ovl_pix_q;
  assign ovl_hit   = ovl_hit_q;
  assign valid_out = sync_q[3][2];
  assign hsync_out = sync_q[3][1];
  assign vsync_out = sync_q[3][0];

endmodule

// File: tb/tb_char_overlay_scan.sv
// Directed bench for char_overlay_scan with a behavioural glyph ROM.
module tb_char_overlay_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic       pix_valid = 1'b0;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic [4:0] char_sel;
  logic [5:0] char_row;
  logic [5:0] char_col;
  logic       glyph_pix = 1'b0;
  logic       ovl_pix, ovl_hit, valid_out, hsync_out, vsync_out;
  bit         force_one = 1'b0;

  int compare_cnt  = 0;
  int mismatch_cnt = 0;

  logic [4:0] tb_mem [32];
  int         q_x[$];
  int         q_y[$];
  bit         q_v[$];
  int         inj_idx  = -1;
  logic [4:0] inj_addr = '0;
  logic [4:0] inj_code = '0;

  char_overlay_scan_if wr_if ();

  char_overlay_scan dut (
    .clk       (clk),
    .rst       (rst),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_valid (pix_valid),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .wr        (wr_if),
    .char_sel  (char_sel),
    .char_row  (char_row),
    .char_col  (char_col),
    .glyph_pix (glyph_pix),
    .ovl_pix   (ovl_pix),
    .ovl_hit   (ovl_hit),
    .valid_out (valid_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out)
  );

  always #5 clk = ~clk;

  function automatic bit glyph_fn(logic [4:0] code, logic [4:0] row, logic [4:0] col);
    return code[0] ^ row[1] ^ col[0] ^ (row[3] & col[2]);
  endfunction

  // Stand-in for the registered disp_char glyph ROM.
  always @(posedge clk) begin
    glyph_pix <= force_one ? 1'b1 : glyph_fn(char_sel, char_row[4:0], char_col[4:0]);
  end

  function automatic bit in_win(int x, int y, bit v);
    return v && (x >= 64) && (x < 576) && (y >= 32) && (y < 96);
  endfunction

  function automatic int tile_addr(int x, int y);
    return ((y - 32) >> 5) * 16 + ((x - 64) >> 5);
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    compare_cnt++;
    assert (obs === exp) else begin
      mismatch_cnt++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pix(int x, int y, bit v);
    q_x.push_back(x);
    q_y.push_back(y);
    q_v.push_back(v);
  endtask

  task automatic doWrite(logic [4:0] addr, logic [4:0] code);
    checkOutput("wr_ready_idle", 32'(wr_if.wr_ready), 32'd1);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = addr;
    wr_if.wr_char  = code;
    @(posedge clk); #1;
    wr_if.wr_valid = 1'b0;
    tb_mem[addr]   = code;
  endtask

  // Streams the queued pixels at one per cycle and checks every output stage.
  task automatic applyStimulus();
    int n;
    int code_at[$];
    n = q_x.size();
    code_at = {};
    for (int k = 0; k < n; k++) code_at.push_back(31);
    for (int i = 0; i < n + 3; i++) begin
      if (i < n) begin
        pix_x     = 10'(q_x[i]);
        pix_y     = 10'(q_y[i]);
        pix_valid = q_v[i];
        hsync_in  = 1'(q_x[i] & 1);
        vsync_in  = 1'(q_y[i] & 1);
      end else begin
        pix_valid = 1'b0;
        hsync_in  = 1'b0;
        vsync_in  = 1'b0;
      end
      if (i == inj_idx) begin
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = inj_addr;
        wr_if.wr_char  = inj_code;
      end else begin
        wr_if.wr_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (i >= 1 && i - 1 < n && in_win(q_x[i-1], q_y[i-1], q_v[i-1]))
        code_at[i-1] = int'(tb_mem[tile_addr(q_x[i-1], q_y[i-1])]);
      if (i == inj_idx) tb_mem[inj_addr] = inj_code;
      if (i >= 1 && i - 1 < n) begin
        int j;
        bit h;
        j = i - 1;
        h = in_win(q_x[j], q_y[j], q_v[j]);
        checkOutput("char_out", {15'd0, char_sel, char_row, char_col},
                    {15'd0, h ? 5'(code_at[j]) : 5'd31,
                     h ? 6'((q_y[j] - 32) & 31) : 6'd0,
                     h ? 6'((q_x[j] - 64) & 31) : 6'd0});
      end
      if (i >= 3) begin
        int  j;
        bit  h, g;
        j = i - 3;
        h = in_win(q_x[j], q_y[j], q_v[j]);
        g = force_one ? 1'b1 : glyph_fn(5'(code_at[j]), 5'((q_y[j] - 32) & 31),
                                        5'((q_x[j] - 64) & 31));
        checkOutput("ovl_out", {30'd0, ovl_hit, ovl_pix},
                    {30'd0, h, h && (code_at[j] <= 16) && g});
        checkOutput("sync_out", {29'd0, valid_out, hsync_out, vsync_out},
                    {29'd0, q_v[j], 1'(q_x[j] & 1), 1'(q_y[j] & 1)});
      end
    end
    wr_if.wr_valid = 1'b0;
    inj_idx = -1;
    q_x = {};
    q_y = {};
    q_v = {};
  endtask

  // Hard time limit so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    int xs[8];
    int ys[8];
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = '0;
    wr_if.wr_char  = '0;
    wr_if.clr      = 1'b0;
    for (int k = 0; k < 32; k++) tb_mem[k] = 5'd31;

    // Reset values while rst is held low.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_vals",
                {10'd0, wr_if.wr_ready, ovl_pix, ovl_hit, valid_out, hsync_out, vsync_out,
                 char_sel, char_row, char_col},
                {10'd0, 6'd0, 5'd31, 6'd0, 6'd0});

    // Auto-clear after reset release takes exactly 32 cycles.
    @(negedge clk);
    rst = 1'b1;
    cycles = 0;
    while (!wr_if.wr_ready && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("ready_after_reset", 32'(cycles), 32'd32);

    // Sparse scan over window edges: all blank, hit only inside.
    xs = '{0, 63, 64, 65, 300, 575, 576, 1023};
    ys = '{0, 31, 32, 63, 64, 95, 96, 1023};
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        push_pix(xs[b], ys[a], 1'b1);
    push_pix(100, 40, 1'b0);
    applyStimulus();

    // Code 5 in tile 0, full tile scan.
    doWrite(5'd0, 5'd5);
    for (int y = 32; y < 64; y++)
      for (int x = 64; x < 96; x++)
        push_pix(x, y, 1'b1);
    applyStimulus();

    // Code 16 at addr 17 plus just-outside pixels.
    doWrite(5'd17, 5'd16);
    push_pix(96, 64, 1'b1);
    push_pix(63, 32, 1'b1);
    push_pix(576, 32, 1'b1);
    applyStimulus();

    // Non-drawing code 20 with the glyph forced high.
    doWrite(5'd1, 5'd20);
    force_one = 1'b1;
    for (int x = 96; x < 128; x++) push_pix(x, 40, 1'b1);
    push_pix(64, 32, 1'b1);
    applyStimulus();
    force_one = 1'b0;
    @(posedge clk); #1;

    // Read-first: write addr 0 on the edge that reads pixel 0's tile.
    push_pix(64, 32, 1'b1);
    push_pix(65, 32, 1'b1);
    push_pix(66, 32, 1'b1);
    inj_idx  = 1;
    inj_addr = 5'd0;
    inj_code = 5'd9;
    applyStimulus();

    // Double clr with wr_valid held high: 42 cycles not ready.
    pix_x = 10'd80; pix_y = 10'd40; pix_valid = 1'b1;
    wr_if.clr = 1'b1;
    @(posedge clk); #1;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_char  = 5'd3;
    cycles = 0;
    while (!wr_if.wr_ready && cycles < 100) begin
      cycles++;
      wr_if.clr     = (cycles == 10);
      wr_if.wr_addr = 5'(cycles);
      @(posedge clk); #1;
    end
    wr_if.wr_valid = 1'b0;
    wr_if.clr      = 1'b0;
    checkOutput("clear_busy_cycles", 32'(cycles), 32'd42);
    for (int k = 0; k < 32; k++) tb_mem[k] = 5'd31;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 16; c++)
        push_pix(64 + 32 * c, 32 + 32 * r, 1'b1);
    applyStimulus();

    // Async reset in the middle of a clear and a scan.
    doWrite(5'd17, 5'd16);
    pix_x = 10'd99; pix_y = 10'd71; pix_valid = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1;
    wr_if.clr = 1'b1;
    @(posedge clk); #1;
    wr_if.clr = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("pre_reset_char", {15'd0, char_sel, char_row, char_col},
                {15'd0, 5'd16, 6'd7, 6'd3});
    checkOutput("pre_reset_sync", {29'd0, valid_out, hsync_out, vsync_out}, 32'd7);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_vals",
                {10'd0, wr_if.wr_ready, ovl_pix, ovl_hit, valid_out, hsync_out, vsync_out,
                 char_sel, char_row, char_col},
                {10'd0, 6'd0, 5'd31, 6'd0, 6'd0});
    #2;
    rst = 1'b1;
    cycles = 0;
    while (!wr_if.wr_ready && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("ready_after_mid_reset", 32'(cycles), 32'd32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule
